// File: rtl/router_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | router_pkg : shared types and constants for the router read   |
// |              side.                      Rev 1.0               |
// +---------------------------------------------------------------+
package router_pkg;

  localparam int NUM_PORTS     = 3;
  localparam int LEN_LSB       = 2;
  localparam int LEN_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    ARB = 2'd0,
    HDR = 2'd1,
    LEN = 2'd2,
    PAY = 2'd3
  } state_e;

  // Port index addition modulo NUM_PORTS; p is a valid port, off is 1..3.
  function automatic logic [1:0] port_add(input logic [1:0] p, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_rr_picker.sv
`default_nettype none
// +---------------------------------------------------------------+
// | router_rr_picker : 3-way round-robin pick starting after      |
// |                    the last served port.       Rev 1.0        |
// +---------------------------------------------------------------+
module router_rr_picker
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last,
  output logic                 pick_vld,
  output logic [1:0]           pick_idx
);

  logic [1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    // Scan farthest offset first so the nearest requester after last wins.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = port_add(last, 2'(i));
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_read_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------+
// | router_read_arbiter : packet-granular round-robin reader that |
// |   merges the three router FIFOs onto one byte stream. Rev 1.0 |
// +---------------------------------------------------------------+
module router_read_arbiter
  import router_pkg::*;
#(
  parameter int STALL_LIMIT = 32,
  parameter int LEN_W       = LEN_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] vld_in,
  input  logic [7:0]           fifo_data0,
  input  logic [7:0]           fifo_data1,
  input  logic [7:0]           fifo_data2,
  output logic [NUM_PORTS-1:0] read_en,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [1:0]           out_port,
  output logic                 abort,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  state_e               state_q, state_d;
  logic [1:0]           g_q, g_d;
  logic [1:0]           last_q, last_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [LEN_W:0]       rem_q, rem_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic                 beat_q, beat_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 abort_q, abort_d;
  logic [1:0]           port_q, port_d;

  logic                 pick_vld;
  logic [1:0]           pick_idx;
  logic [7:0]           g_data;
  logic [7:0]           beat_data;
  logic [LEN_W-1:0]     hdr_len;
  logic [LEN_W-1:0]     eff_len;
  logic                 vld_g;
  logic                 stalled;

  router_rr_picker u_picker (
    .req      (vld_in),
    .last     (last_q),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  always_comb begin
    case (g_q)
      2'd0:    g_data = fifo_data0;
      2'd1:    g_data = fifo_data1;
      2'd2:    g_data = fifo_data2;
      default: g_data = 8'd0;
    endcase
  end

  always_comb begin
    case (port_q)
      2'd0:    beat_data = fifo_data0;
      2'd1:    beat_data = fifo_data1;
      2'd2:    beat_data = fifo_data2;
      default: beat_data = 8'd0;
    endcase
  end

  assign vld_g   = vld_in[g_q];
  assign hdr_len = LEN_W'(g_data >> LEN_LSB);
  assign eff_len = (hdr_len == '0) ? LEN_W'(1) : hdr_len;
  // Waiting on an empty FIFO only counts when the consumer is able to take data.
  assign stalled = ((state_q == HDR) || (state_q == PAY)) && out_ready && !vld_g;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    beat_d  = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    abort_d = 1'b0;
    port_d  = 2'd0;

    case (state_q)
      ARB: begin
        if (pick_vld) begin
          g_d     = pick_idx;
          grant_d = NUM_PORTS'(1) << pick_idx;
          stall_d = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (out_ready && vld_g) begin
          beat_d  = 1'b1;
          sop_d   = 1'b1;
          port_d  = g_q;
          stall_d = '0;
          state_d = LEN;
        end
      end
      LEN: begin
        rem_d   = (LEN_W+1)'(eff_len) + (LEN_W+1)'(1);
        state_d = PAY;
      end
      PAY: begin
        if (out_ready && vld_g) begin
          beat_d  = 1'b1;
          port_d  = g_q;
          stall_d = '0;
          rem_d   = rem_q - (LEN_W+1)'(1);
          if (rem_q == (LEN_W+1)'(1)) begin
            eop_d   = 1'b1;
            last_d  = g_q;
            grant_d = '0;
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase

    if (stalled) begin
      if (stall_q == CNT_W'(STALL_LIMIT - 1)) begin
        abort_d = 1'b1;
        last_d  = g_q;
        grant_d = '0;
        rem_d   = '0;
        stall_d = '0;
        state_d = ARB;
      end else begin
        stall_d = stall_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      g_q     <= 2'd0;
      last_q  <= 2'd2;
      grant_q <= '0;
      rem_q   <= '0;
      stall_q <= '0;
      beat_q  <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      abort_q <= 1'b0;
      port_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      beat_q  <= beat_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      abort_q <= abort_d;
      port_q  <= port_d;
    end
  end

  // The FIFO output register is the data stage; only the beat flags are held here.
  assign read_en   = beat_d ? grant_q : '0;
  assign grant     = grant_q;
  assign out_valid = beat_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_port  = port_q;
  assign out_data  = beat_q ? beat_data : 8'd0;
  assign abort     = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_router_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------+
// | tb_router_read_arbiter : scoreboard bench with a 3-FIFO model.|
// |                                                    Rev 1.0    |
// +---------------------------------------------------------------+
module tb_router_read_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } beat_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] vld_in = 3'b000;
  logic [7:0] fd [3];
  logic [2:0] read_en;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop;
  logic [1:0] out_port;
  logic       abort;
  logic [2:0] grant;

  logic [2:0] en;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  beat_t      sb[$];
  int         rd_cnt [3];
  int         n_checks = 0, n_errors = 0;
  int         abort_cnt, stall_cyc, g0_cyc, eop_cnt;
  logic [2:0] first_grant;

  router_read_arbiter #(.STALL_LIMIT(32), .LEN_W(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vld_in    (vld_in),
    .fifo_data0(fd[0]),
    .fifo_data1(fd[1]),
    .fifo_data2(fd[2]),
    .read_en   (read_en),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_port  (out_port),
    .abort     (abort),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int n);
    case (n)
      0:       return fq0.size();
      1:       return fq1.size();
      default: return fq2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int n);
    case (n)
      0:       return fq0.pop_front();
      1:       return fq1.pop_front();
      default: return fq2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int n, input logic [7:0] b);
    case (n)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  task automatic qclear_all();
    fq0.delete();
    fq1.delete();
    fq2.delete();
  endtask

  // Router FIFO model: registered data, non-empty flag updated on the clock edge.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (read_en[n]) begin
        check("rd_while_vld", {31'd0, vld_in[n]}, 32'd1);
        check("rd_while_ready", {31'd0, out_ready}, 32'd1);
        if (qsize(n) != 0) fd[n] <= qpop(n);
        rd_cnt[n]++;
      end
      vld_in[n] <= en[n] && (qsize(n) != 0);
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rstn) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("beat_data", {24'd0, out_data}, {24'd0, e.data});
          check("beat_sop",  {31'd0, out_sop},  {31'd0, e.sop});
          check("beat_eop",  {31'd0, out_eop},  {31'd0, e.eop});
          check("beat_port", {30'd0, out_port}, {30'd0, e.port});
        end
      end
      if (abort) abort_cnt++;
      if (out_eop) eop_cnt++;
      if (grant == 3'b001) g0_cyc++;
      if (grant != 3'b000 && out_ready && ((vld_in & grant) == 3'b000)) stall_cyc++;
      if (grant != 3'b000 && first_grant == 3'b000) first_grant = grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue a packet into FIFO p; only the first `keep` bytes are written (keep<0: all).
  task automatic load_pkt(input int p, input int len, input logic [7:0] seed, input int keep);
    int         eff, total;
    logic [7:0] b, par;
    beat_t      e;
    eff   = (len == 0) ? 1 : len;
    total = eff + 2;
    par   = 8'd0;
    for (int i = 0; i < total; i++) begin
      if (i == 0)              b = {6'(len), 2'(p)};
      else if (i == total - 1) b = par;
      else                     b = seed + 8'(i);
      if (i != total - 1) par = par ^ b;
      if (keep < 0 || i < keep) begin
        qpush(p, b);
        e.data = b;
        e.sop  = (i == 0);
        e.eop  = (i == total - 1);
        e.port = 2'(p);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || (qsize(0) + qsize(1) + qsize(2)) != 0 || grant != 3'b000) && n < 2000) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (n < 2000)}, 32'd1);
  endtask

  task automatic wait_reads(input string tag, input int p, input int target);
    int n = 0;
    while (rd_cnt[p] < target && n < 500) begin
      tick();
      n++;
    end
    check(tag, {31'd0, (n < 500)}, 32'd1);
  endtask

  initial begin
    int base, r;
    rstn      = 1'b0;
    out_ready = 1'b1;
    en        = 3'b111;
    fd[0] = 8'd0; fd[1] = 8'd0; fd[2] = 8'd0;
    rd_cnt[0] = 0; rd_cnt[1] = 0; rd_cnt[2] = 0;
    abort_cnt = 0; stall_cyc = 0; g0_cyc = 0; eop_cnt = 0;
    first_grant = 3'b000;
    repeat (3) tick();

    check("rst_grant",     {29'd0, grant},     32'd0);
    check("rst_read_en",   {29'd0, read_en},   32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_abort",     {31'd0, abort},     32'd0);
    rstn = 1'b1;
    tick();

    // Reset priority: single packet, header 0x0C
    base = rd_cnt[0]; g0_cyc = 0;
    load_pkt(0, 3, 8'h10, -1);
    drain("t1_drain");
    check("t1_reads",        rd_cnt[0] - base, 32'd5);
    check("t1_grant_cycles", g0_cyc,           32'd6);
    check("t1_eop_count",    eop_cnt,          32'd1);

    // Round-robin from reset, plus a zero-length refill on FIFO0
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    load_pkt(0, 1, 8'h20, -1);
    load_pkt(1, 1, 8'h30, -1);
    load_pkt(2, 1, 8'h40, -1);
    drain("t2_drain");
    load_pkt(0, 0, 8'h50, -1);
    drain("t2_refill_drain");
    check("t2_eop_count", eop_cnt, 32'd5);

    // Back-pressure, including a long not-ready window over an empty FIFO
    base = rd_cnt[0];
    load_pkt(0, 4, 8'h60, -1);
    wait_reads("t3_wait", 0, base + 2);
    out_ready = 1'b0; tick(); tick();
    out_ready = 1'b1; tick();
    r = rd_cnt[0];
    out_ready = 1'b0; en[0] = 1'b0;
    repeat (40) tick();
    check("t3_no_read_when_low", rd_cnt[0] - r, 32'd0);
    out_ready = 1'b1;
    repeat (20) tick();
    en[0] = 1'b1;
    drain("t3_drain");
    check("t3_no_abort", abort_cnt, 32'd0);

    // Slow writer: FIFO0 empty for 5 cycles mid-payload
    base = rd_cnt[0];
    load_pkt(0, 6, 8'h70, -1);
    wait_reads("t4_wait", 0, base + 3);
    en[0] = 1'b0;
    tick();
    r = rd_cnt[0];
    repeat (5) tick();
    check("t4_paused", rd_cnt[0] - r, 32'd0);
    en[0] = 1'b1;
    drain("t4_drain");
    check("t4_no_abort", abort_cnt, 32'd0);

    // Abort: FIFO1 runs dry after 3 payload bytes; FIFO2 then FIFO0 follow
    abort_cnt = 0; stall_cyc = 0; r = eop_cnt;
    load_pkt(1, 8, 8'h80, 4);
    load_pkt(2, 1, 8'h90, -1);
    load_pkt(0, 2, 8'hA0, -1);
    drain("t5_drain");
    check("t5_abort_count", abort_cnt,     32'd1);
    check("t5_stall_cycles", stall_cyc,    32'd32);
    check("t5_eop_count",   eop_cnt - r,   32'd2);

    // Asynchronous reset in the middle of a payload
    base = rd_cnt[1];
    load_pkt(1, 10, 8'hB0, -1);
    wait_reads("t6_wait", 1, base + 4);
    #1 rstn = 1'b0;
    #1;
    check("t6_rst_grant",     {29'd0, grant},     32'd0);
    check("t6_rst_read_en",   {29'd0, read_en},   32'd0);
    check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_out_data",  {24'd0, out_data},  32'd0);
    check("t6_rst_out_port",  {30'd0, out_port},  32'd0);
    qclear_all();
    sb.delete();
    tick();
    first_grant = 3'b000;
    rstn = 1'b1;
    tick();
    load_pkt(0, 2, 8'hC0, -1);
    load_pkt(1, 1, 8'hD0, -1);
    drain("t6_drain");
    check("t6_first_grant", {29'd0, first_grant}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
